flag_counter_display: RTL and testbench

Receiving end of the sensor FSM's `count_flag` pulse. Accumulates entry pulses (and exit pulses from the second sensor channel) into a saturating 4-digit BCD count. Drives the count onto the board's multiplexed, active-low 7-segment display. Sits between the sensor FSM instances and the display pins.

---
 rtl/display_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 34 +++
 rtl/flag_counter_display.sv | 152 +++++++++++++++
 tb/tb_flag_counter_display.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_pkg : shared 7-segment patterns and display defaults      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package display_pkg;

  localparam int DIGITS_DEFAULT      = 4;
  localparam int REFRESH_DIV_DEFAULT = 100000;

  // Active-low cathodes, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_decoder : BCD digit plus blank -> active-low segment pattern |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/flag_counter_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flag_counter_display : saturating BCD up/down count of sensor     |
// | flag edges, shown on a multiplexed active-low 7-segment display   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module flag_counter_display
  import display_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEFAULT,
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                count_flag,
  input  logic                dec_flag,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                at_zero,
  output logic                at_max,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int W      = 4 * DIGITS;
  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              count_flag_dly_q, dec_flag_dly_q;
  logic              inc_ev, dec_ev;
  logic [W-1:0]      count_q, count_d, inc_val, dec_val;
  logic              at_zero_q, at_zero_d, at_max_q, at_max_d;
  logic              carry, borrow, all_nines, lead;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d, blank_vec;
  logic [3:0]        sel_bcd;
  logic              sel_blank;
  logic [6:0]        seg_q, seg_dec;

  assign inc_ev = count_flag & ~count_flag_dly_q;
  assign dec_ev = dec_flag & ~dec_flag_dly_q;

  // Ripple carry/borrow across all digits within the cycle
  always_comb begin
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!(inc_ev && dec_ev)) begin
      if (inc_ev && !at_max_q)       count_d = inc_val;
      else if (dec_ev && !at_zero_q) count_d = dec_val;
    end
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_nines = all_nines && (count_d[4*i +: 4] == 4'd9);
    end
    at_zero_d = (count_d == '0);
    at_max_d  = all_nines;
  end

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is blank when it and every digit above it are zero
  always_comb begin
    blank_vec = '0;
    lead      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead         = lead && (count_q[4*i +: 4] == 4'd0);
      blank_vec[i] = lead;
    end
    sel_bcd   = count_q[3:0];
    sel_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_bcd   = count_q[4*i +: 4];
        sel_blank = blank_vec[i];
        an_d[i]   = 1'b0;
      end
    end
  end

  seg7_decoder u_dec (
    .bcd   (sel_bcd),
    .blank (sel_blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_flag_dly_q <= 1'b0;
      dec_flag_dly_q   <= 1'b0;
      count_q          <= '0;
      at_zero_q        <= 1'b1;
      at_max_q         <= 1'b0;
      scan_q           <= '0;
      idx_q            <= '0;
      an_q             <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_q            <= SEG_0;
    end else begin
      count_flag_dly_q <= count_flag;
      dec_flag_dly_q   <= dec_flag;
      count_q          <= count_d;
      at_zero_q        <= at_zero_d;
      at_max_q         <= at_max_d;
      scan_q           <= scan_d;
      idx_q            <= idx_d;
      an_q             <= an_d;
      seg_q            <= seg_dec;
    end
  end

  assign count_bcd = count_q;
  assign at_zero   = at_zero_q;
  assign at_max    = at_max_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_counter_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_flag_counter_display : directed self-checking bench            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_flag_counter_display;

  logic        clk;
  logic        reset;
  logic        count_flag;
  logic        dec_flag;
  logic        clear;
  logic [15:0] count_bcd;
  logic        at_zero;
  logic        at_max;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;

  flag_counter_display #(
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count_flag (count_flag),
    .dec_flag   (dec_flag),
    .clear      (clear),
    .count_bcd  (count_bcd),
    .at_zero    (at_zero),
    .at_max     (at_max),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inc(input int n);
    for (int k = 0; k < n; k++) begin
      count_flag = 1'b1;
      @(negedge clk);
      count_flag = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_dec(input int n);
    for (int k = 0; k < n; k++) begin
      dec_flag = 1'b1;
      @(negedge clk);
      dec_flag = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  int         waited;

  initial begin
    exp_an[0]  = 4'b1110; exp_an[1]  = 4'b1101; exp_an[2]  = 4'b1011; exp_an[3]  = 4'b0111;
    exp_seg[0] = 7'b0100100; exp_seg[1] = 7'b0011001;
    exp_seg[2] = 7'b1111111; exp_seg[3] = 7'b1111111;

    reset = 1'b0; count_flag = 1'b0; dec_flag = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", count_bcd, 16'h0000);
    check("rst_at_zero", at_zero, 1'b1);
    check("rst_at_max", at_max, 1'b0);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    reset = 1'b1;
    @(negedge clk);

    pulse_inc(3);
    check("three_pulses", count_bcd, 16'h0003);
    check("nonzero_flag", at_zero, 1'b0);
    count_flag = 1'b1;
    repeat (10) @(negedge clk);
    count_flag = 1'b0;
    @(negedge clk);
    check("held_level", count_bcd, 16'h0004);

    // Asynchronous reset in the middle of a cycle, sampled before any edge
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", count_bcd, 16'h0000);
    check("async_rst_at_zero", at_zero, 1'b1);
    check("async_rst_an", an, 4'b1110);
    check("async_rst_seg", seg, 7'b1000000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    pulse_inc(99);
    check("preload_99", count_bcd, 16'h0099);
    pulse_inc(1);
    check("carry_100", count_bcd, 16'h0100);
    pulse_dec(1);
    check("borrow_99", count_bcd, 16'h0099);

    pulse_inc(9900);
    check("reach_9999", count_bcd, 16'h9999);
    check("reach_at_max", at_max, 1'b1);
    pulse_inc(1);
    check("sat_max_count", count_bcd, 16'h9999);
    check("sat_max_flag", at_max, 1'b1);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_count", count_bcd, 16'h0000);
    pulse_dec(1);
    check("sat_zero_count", count_bcd, 16'h0000);
    check("sat_zero_flag", at_zero, 1'b1);

    pulse_inc(5);
    check("preload_5", count_bcd, 16'h0005);
    count_flag = 1'b1; dec_flag = 1'b1;
    @(negedge clk);
    count_flag = 1'b0; dec_flag = 1'b0;
    @(negedge clk);
    check("both_events", count_bcd, 16'h0005);
    clear = 1'b1; count_flag = 1'b1;
    @(negedge clk);
    clear = 1'b0; count_flag = 1'b0;
    @(negedge clk);
    check("clear_wins", count_bcd, 16'h0000);

    pulse_inc(42);
    check("preload_42", count_bcd, 16'h0042);

    // Find the first cycle of a digit-0 dwell
    waited = 0;
    while (an == 4'b1110 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    while (an != 4'b1110 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("scan_align", (waited < 40) ? 1 : 0, 1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("scan_an_d%0d_c%0d", d, c), an, exp_an[d]);
        check($sformatf("scan_seg_d%0d_c%0d", d, c), seg, exp_seg[d]);
        @(negedge clk);
      end
    end
    check("scan_wrap_an", an, 4'b1110);
    check("scan_wrap_seg", seg, 7'b0100100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
